tt_tbuf_bus_arb: RTL
====================

// Module: tt_tbuf_bus_arb
// PURPOSE
// - Round-robin arbiter/sequencer for a shared tristate bus built from tt_prim_tbuf cells.
// - One enable per requester; positive polarity; each feeds a tt_prim_tbuf_pol 't' input.
// - Guarantees at most one driver at any time.
// - Break-before-make: a dead (turnaround) gap always separates two owners.
// PARAMETERS
// - N_REQ     4   number of requesters (2..16)
// - TURN_CYC  2   dead cycles, all oe low, after an owner releases (>=1)
// - MAX_HOLD  16  max DRIVE cycles before forced release (used only with the macro)
// PORTS
// - clk      in   1                  clock
// - rst_n    in   1                  asynchronous reset, active-low
// - req      in   N_REQ              level request per requester
// - gnt      out  N_REQ              one-hot ownership grant, registered
// - oe       out  N_REQ              one-hot tristate enable (positive), registered
// - owner    out  $clog2(N_REQ)      index of current/last owner
// - busy     out  1                  high whenever state != IDLE
// - preempt  out  1                  1-cycle pulse on forced release (tied 0 without macro)
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; gnt=0, oe=0, owner=0, busy=0, preempt=0; rr_ptr=0; counters=0.
// - Arbitration: scan req from rr_ptr upward with wrap; first set bit wins.
// - States and transitions:
//   - IDLE: if |req, latch winner; next cycle SETUP.
//   - SETUP (1 cycle): gnt[w]=1, oe=0; requester presents data.
//     - req[w] still high: -> DRIVE.
//     - req[w] dropped: -> IDLE; bus was never driven, so no turnaround.
//   - DRIVE: gnt[w]=1, oe[w]=1; held while req[w]=1.
//     - req[w] low: next cycle gnt=0, oe=0, state TURN.
//     - Turn counter loads TURN_CYC; rr_ptr = (w+1) mod N_REQ.
//   - TURN: gnt=0, oe=0 for exactly TURN_CYC cycles.
//     - Last cycle arbitrates: winner -> SETUP, else -> IDLE.
// - Latency (min):
//   - req rise in IDLE -> gnt 1 cycle.
//   - req rise in IDLE -> oe 2 cycles.
//   - oe fall -> next oe rise: TURN_CYC+1 cycles.
// - gnt and oe fall on the same edge; oe never high without gnt.
// - oe is never high for two requesters simultaneously.
// - Requests are level; none are stored. A req pulse that drops before it is sampled is lost.
// - rr_ptr updates only on release or SETUP abort. Releaser has lowest priority in the next arbitration.
// - Owner dropping and re-raising req within TURN is an ordinary new request, subject to rr_ptr.
// - owner updates when SETUP is entered and holds through TURN/IDLE.
// - Asynchronous reset mid-DRIVE drops oe/gnt immediately (no turnaround).
// - Requester-side logic must tolerate the dropped oe/gnt.
// CONFIGURATION
// - Macro TT_TBUF_ARB_TIMEOUT_EN.
// - Defined:
//   - Hold counter clears on DRIVE entry and increments each DRIVE cycle.
//   - When it reaches MAX_HOLD and any other req bit is set, DRIVE exits as a normal release.
//   - On that release edge, preempt pulses for 1 cycle.
//   - With no competing request, the owner holds indefinitely.
// - Undefined:
//   - No hold counter; preempt is constant 0.
//   - Ownership ends only when req[w] drops.
// TESTING
// - Reset with req=4'b1111 held -> gnt=0/oe=0 during reset.
//   - Release: gnt=0001 at +1 cycle, oe=0001 at +2 cycles.
// - req=0101, owner 0 drops req[0] -> oe=0 for 2 cycles, then gnt=0100 for 1 cycle, then oe=0100.
// - All four req held; each owner releases after 3 DRIVE cycles -> grant order 0,1,2,3,0.
//   - oe never overlaps; oe never has more than one bit set.
// - req[2] pulse high 1 cycle in IDLE -> gnt=0100 for 1 cycle (SETUP), then IDLE.
//   - oe stays 0; next grant goes to 3 first.
// - TT_TBUF_ARB_TIMEOUT_EN, MAX_HOLD=16: req[1] held, req[3] raised.
//   - After 16 DRIVE cycles: preempt=1, oe=0; 2 TURN cycles; gnt=1000.
// - Assert rst_n=0 mid-DRIVE -> oe=gnt=0 asynchronously; busy=0.
// - Formal/assertion: $onehot0(oe) && ((oe & ~gnt)==0) on every cycle.

Source files
------------

// File: rtl/tt_tbuf_bus_arb.sv
// rtl/tt_tbuf_bus_arb.sv - round-robin break-before-make arbiter for a shared tristate bus
// Optional forced release after MAX_HOLD drive cycles: define TT_TBUF_ARB_TIMEOUT_EN.
module tt_tbuf_bus_arb #(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         oe,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     preempt
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TURN_CYC + 1);

    if (N_REQ < 2 || N_REQ > 16 || TURN_CYC < 1 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("tt_tbuf_bus_arb: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, SETUP, DRIVE, TURN} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     rr_ptr, rr_nxt, owner_nxt, owner_inc, arb_idx;
    logic [TW-1:0]     turn_cnt, turn_nxt;
    logic [N_REQ-1:0]  owner_oh, owner_oh_nxt, gnt_nxt, oe_nxt;
    logic              busy_nxt, preempt_nxt, arb_found, force_rel;
    logic [IW:0]       j;

    assign owner_oh  = N_REQ'(1) << owner;
    assign owner_inc = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // Scan from rr_ptr upward with wrap; first requester found wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        j         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = {1'b0, rr_ptr} + (IW + 1)'(i);
            if (j >= (IW + 1)'(N_REQ)) j = j - (IW + 1)'(N_REQ);
            if (!arb_found && req[j[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = j[IW-1:0];
            end
        end
    end

`ifdef TT_TBUF_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;

    // Counts completed DRIVE cycles of the current tenure; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state != DRIVE) begin
            hold_cnt <= '0;
        end else if (hold_cnt < HW'(MAX_HOLD - 1)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign force_rel = (state == DRIVE) && req[owner] &&
                       (hold_cnt >= HW'(MAX_HOLD - 1)) && (|(req & ~owner_oh));
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_nxt      = rr_ptr;
        turn_nxt    = turn_cnt;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt = SETUP;
                    owner_nxt = arb_idx;
                end
            end
            SETUP: begin
                if (req[owner]) begin
                    state_nxt = DRIVE;
                end else begin
                    // Bus never driven, so no turnaround is needed.
                    state_nxt = IDLE;
                    rr_nxt    = owner_inc;
                end
            end
            DRIVE: begin
                if (!req[owner] || force_rel) begin
                    state_nxt   = TURN;
                    turn_nxt    = TW'(TURN_CYC);
                    rr_nxt      = owner_inc;
                    preempt_nxt = force_rel;
                end
            end
            TURN: begin
                if (turn_cnt <= TW'(1)) begin
                    if (arb_found) begin
                        state_nxt = SETUP;
                        owner_nxt = arb_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    turn_nxt = turn_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        owner_oh_nxt = N_REQ'(1) << owner_nxt;
        gnt_nxt      = (state_nxt == SETUP || state_nxt == DRIVE) ? owner_oh_nxt : '0;
        oe_nxt       = (state_nxt == DRIVE) ? owner_oh_nxt : '0;
        busy_nxt     = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            turn_cnt <= '0;
            owner    <= '0;
            gnt      <= '0;
            oe       <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            turn_cnt <= turn_nxt;
            owner    <= owner_nxt;
            gnt      <= gnt_nxt;
            oe       <= oe_nxt;
            busy     <= busy_nxt;
            preempt  <= preempt_nxt;
        end
    end
endmodule
